// File: rtl/merge_recv_xc_pkg.sv
// merge_recv_xc_pkg: shared lane state encoding, word widths and frame length helper
package merge_recv_xc_pkg;
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} lane_state_t;
  localparam int DATA_WIDTH = 64;
  localparam int HALF_WIDTH = 32;
  function automatic logic [31:0] eff_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction
endpackage

// File: rtl/merge_recv_xc_receiver.sv
// req_ack_32bit_receiver: synchronized 4-phase lane receiver packing two halves into one word slot
module req_ack_32bit_receiver
  import merge_recv_xc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  request,
  input  logic [HALF_WIDTH-1:0] din,
  input  logic                  drain,
  output logic                  acknowledge,
  output logic [DATA_WIDTH-1:0] slot_data,
  output logic                  slot_valid
);
  logic [SYNC_STAGES-1:0] sync;
  lane_state_t state;
  logic half;
  logic req_s;
  assign req_s = sync[SYNC_STAGES-1];
  assign acknowledge = state == ACK;
  always_ff @(posedge clk)
    sync <= rst ? '0 : {sync[SYNC_STAGES-2:0], request};
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      half       <= 1'b0;
      slot_data  <= '0;
      slot_valid <= 1'b0;
    end else begin
      if (drain) slot_valid <= 1'b0;
      if (state == IDLE && req_s && !slot_valid) begin
        state <= ACK;
        half  <= ~half;
        if (half) begin
          slot_data[DATA_WIDTH-1:HALF_WIDTH] <= din;
          slot_valid <= 1'b1;
        end else begin
          slot_data[HALF_WIDTH-1:0] <= din;
        end
      end else if (state == ACK && !req_s) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: rtl/merge_recv_xc.sv
// merge_recv_xc: merges per-lane 4-phase receivers into a round-robin AXI-stream with frame framing
module merge_recv_xc
  import merge_recv_xc_pkg::*;
#(
  parameter int Channel     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [Channel-1:0]            request,
  input  logic [Channel*HALF_WIDTH-1:0] din,
  output logic [Channel-1:0]            acknowledge,
  input  logic [31:0]                   i_rx_len,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic                          o_rx_done
);
  localparam int IW = Channel > 1 ? $clog2(Channel) : 1;
  logic [DATA_WIDTH-1:0] slot_data [Channel];
  logic [Channel-1:0] slot_valid, drain;
  logic [IW-1:0] ptr, gnt;
  logic gnt_valid, load, hs;
  logic [31:0] cnt, cnt_nxt, len_q, len_nxt;
  for (genvar i = 0; i < Channel; i++) begin : g_lane
    req_ack_32bit_receiver #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
      .clk,
      .rst,
      .request(request[i]),
      .din(din[i*HALF_WIDTH +: HALF_WIDTH]),
      .drain(drain[i]),
      .acknowledge(acknowledge[i]),
      .slot_data(slot_data[i]),
      .slot_valid(slot_valid[i])
    );
  end
  always_comb begin
    gnt_valid = 1'b0;
    gnt = '0;
    for (int k = Channel - 1; k >= 0; k--)
      if (slot_valid[IW'((int'(ptr) + k) % Channel)]) begin
        gnt_valid = 1'b1;
        gnt = IW'((int'(ptr) + k) % Channel);
      end
  end
  assign hs = m_axis_tvalid && m_axis_tready;
  assign load = gnt_valid && (!m_axis_tvalid || m_axis_tready);
  assign drain = load ? Channel'(1) << gnt : '0;
  assign cnt_nxt = hs ? (m_axis_tlast ? '0 : cnt + 32'd1) : cnt;
  assign len_nxt = cnt_nxt == '0 ? eff_len(i_rx_len) : len_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      cnt           <= '0;
      len_q         <= 32'd1;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      o_rx_done     <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      len_q     <= len_nxt;
      o_rx_done <= hs && m_axis_tlast;
      if (load) begin
        m_axis_tdata  <= slot_data[gnt];
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= cnt_nxt == len_nxt - 32'd1;
        ptr           <= gnt == IW'(Channel - 1) ? '0 : gnt + 1'b1;
      end else if (hs) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_merge_recv_xc.sv
// tb_merge_recv_xc: directed self-checking bench for the merged 4-phase receiver
module tb_merge_recv_xc;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] request, acknowledge;
  logic [127:0] din;
  logic [31:0] i_rx_len;
  logic m_axis_tready, m_axis_tvalid, m_axis_tlast, o_rx_done;
  logic [63:0] m_axis_tdata;
  logic req_a [4];
  logic [31:0] din_a [4];
  int tests = 0, failed = 0;
  int done_err = 0, done_cnt = 0, stab_err = 0, to_err = 0, cyc = 0, senders_done = 0;
  logic [63:0] words [$];
  logic lasts [$];
  int cycs [$];
  logic hs, hs_last_prev = 1'b0, stall_prev = 1'b0, last_prev = 1'b0;
  logic [63:0] dat_prev = '0;
  assign request = {req_a[3], req_a[2], req_a[1], req_a[0]};
  assign din = {din_a[3], din_a[2], din_a[1], din_a[0]};
  always #5 clk = ~clk;
  merge_recv_xc #(.Channel(4), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .request(request),
    .din(din),
    .acknowledge(acknowledge),
    .i_rx_len(i_rx_len),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .o_rx_done(o_rx_done)
  );
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (o_rx_done !== hs_last_prev) done_err++;
      if (o_rx_done === 1'b1) done_cnt++;
      if (stall_prev && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== dat_prev || m_axis_tlast !== last_prev)) stab_err++;
    end
    hs = !rst && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1;
    if (hs) begin
      words.push_back(m_axis_tdata);
      lasts.push_back(m_axis_tlast);
      cycs.push_back(cyc);
    end
    hs_last_prev = hs && m_axis_tlast === 1'b1;
    stall_prev = !rst && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b0;
    dat_prev = m_axis_tdata;
    last_prev = m_axis_tlast;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] wexp(input int lane, input int w);
    logic [31:0] lo;
    lo = 32'h50000000 + 32'(lane * 256 + w * 16);
    return {lo + 32'd1, lo};
  endfunction
  task automatic send_half(input int lane, input logic [31:0] d, output int up, output int dn);
    din_a[lane] = d;
    req_a[lane] = 1'b1;
    up = 0;
    do begin @(negedge clk); up++; end while (acknowledge[lane] !== 1'b1 && up < 300);
    if (up >= 300) to_err++;
    req_a[lane] = 1'b0;
    dn = 0;
    do begin @(negedge clk); dn++; end while (acknowledge[lane] !== 1'b0 && dn < 300);
    if (dn >= 300) to_err++;
  endtask
  task automatic send_word(input int lane, input logic [31:0] lo, input logic [31:0] hi);
    int u, d;
    send_half(lane, lo, u, d);
    send_half(lane, hi, u, d);
  endtask
  task automatic send_n(input int lane);
    logic [63:0] e;
    for (int w = 0; w < 3; w++) begin
      e = wexp(lane, w);
      send_word(lane, e[31:0], e[63:32]);
    end
    senders_done++;
  endtask
  task automatic wait_words(input int n);
    int c = 0;
    while (words.size() < n && c < 1000) begin @(negedge clk); c++; end
    if (c >= 1000) to_err++;
  endtask
  task automatic wait_ack(input int lane, input logic v);
    int c = 0;
    while (acknowledge[lane] !== v && c < 100) begin @(negedge clk); c++; end
    if (c >= 100) to_err++;
  endtask
  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 m_axis_tready = v;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    words.delete();
    lasts.delete();
    cycs.delete();
    done_cnt = 0;
  endtask
  initial begin
    int up, dn, n, c;
    for (int i = 0; i < 4; i++) begin
      req_a[i] = 1'b0;
      din_a[i] = '0;
    end
    rst = 1'b1;
    i_rx_len = 32'd0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 64'(acknowledge), 64'h0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'h0);
    chk("rst_tdata", m_axis_tdata, 64'h0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'h0);
    chk("rst_done", 64'(o_rx_done), 64'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    send_half(0, 32'h11111111, up, dn);
    chk("t1_ack_rise1", 64'(up), 64'd3);
    chk("t1_ack_fall1", 64'(dn), 64'd3);
    send_half(0, 32'h22222222, up, dn);
    chk("t1_ack_rise2", 64'(up), 64'd3);
    chk("t1_ack_fall2", 64'(dn), 64'd3);
    wait_words(1);
    chk("t1_count", 64'(words.size()), 64'd1);
    chk("t1_word", words[0], 64'h22222222_11111111);
    chk("t1_last", 64'(lasts[0]), 64'd1);
    chk("t1_ack_idle", 64'(acknowledge), 64'h0);
    set_ready(1'b0);
    do_reset();
    fork
      send_word(0, 32'hA0000000, 32'hB0000000);
      send_word(1, 32'hA0000001, 32'hB0000001);
      send_word(2, 32'hA0000002, 32'hB0000002);
      send_word(3, 32'hA0000003, 32'hB0000003);
    join
    chk("t2_stall_none", 64'(words.size()), 64'd0);
    chk("t2_stall_tdata", m_axis_tdata, 64'hB0000000_A0000000);
    set_ready(1'b1);
    wait_words(4);
    for (int j = 0; j < 4; j++)
      chk($sformatf("t2_r1_%0d", j), words[j], {32'hB0000000 + 32'(j), 32'hA0000000 + 32'(j)});
    fork
      send_word(0, 32'hC0000000, 32'hD0000000);
      send_word(1, 32'hC0000001, 32'hD0000001);
      send_word(2, 32'hC0000002, 32'hD0000002);
      send_word(3, 32'hC0000003, 32'hD0000003);
    join
    wait_words(8);
    for (int j = 0; j < 4; j++)
      chk($sformatf("t2_r2_%0d", j), words[4 + j], {32'hD0000000 + 32'(j), 32'hC0000000 + 32'(j)});
    chk("t2_back_to_back", 64'(cycs[7] - cycs[4]), 64'd3);
    set_ready(1'b0);
    do_reset();
    senders_done = 0;
    fork
      send_n(0);
      send_n(1);
      send_n(2);
      send_n(3);
    join_none
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("t3_stall_none", 64'(words.size()), 64'd0);
    chk("t3_ack_stalled", 64'(acknowledge), 64'h0);
    chk("t3_tvalid_held", 64'(m_axis_tvalid), 64'd1);
    chk("t3_tdata_held", m_axis_tdata, wexp(0, 0));
    set_ready(1'b1);
    c = 0;
    while ((senders_done < 4 || words.size() < 12) && c < 2000) begin @(negedge clk); c++; end
    if (c >= 2000) to_err++;
    repeat (4) @(negedge clk);
    chk("t3_count", 64'(words.size()), 64'd12);
    chk("t3_stable", 64'(stab_err), 64'd0);
    for (int j = 0; j < 4; j++) begin
      n = 0;
      for (int k = 0; k < words.size(); k++)
        if (words[k][11:8] == 4'(j)) begin
          chk($sformatf("t3_l%0d_w%0d", j, n), words[k], wexp(j, n));
          n++;
        end
      chk($sformatf("t3_l%0d_n", j), 64'(n), 64'd3);
    end
    i_rx_len = 32'd5;
    do_reset();
    for (int w = 0; w < 5; w++) send_word(0, 32'h60000000 + 32'(w), 32'h61000000 + 32'(w));
    wait_words(5);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) chk($sformatf("t4_last_%0d", k), 64'(lasts[k]), 64'(k == 4));
    chk("t4_done_cnt", 64'(done_cnt), 64'd1);
    i_rx_len = 32'd0;
    send_word(0, 32'h70000000, 32'h71000000);
    send_word(0, 32'h70000001, 32'h71000001);
    wait_words(7);
    repeat (3) @(negedge clk);
    chk("t4_len0_last_a", 64'(lasts[5]), 64'd1);
    chk("t4_len0_last_b", 64'(lasts[6]), 64'd1);
    chk("t4_len0_done_cnt", 64'(done_cnt), 64'd3);
    chk("t4_done_timing", 64'(done_err), 64'd0);
    do_reset();
    @(negedge clk);
    din_a[2] = 32'hDEAD0001;
    req_a[2] = 1'b1;
    wait_ack(2, 1'b1);
    chk("t5_ack_first", 64'(acknowledge[2]), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_ack_rst", 64'(acknowledge), 64'h0);
    din_a[2] = 32'h33333333;
    @(posedge clk);
    #2 rst = 1'b0;
    wait_ack(2, 1'b1);
    chk("t5_ack_reup", 64'(acknowledge[2]), 64'd1);
    req_a[2] = 1'b0;
    wait_ack(2, 1'b0);
    send_half(2, 32'h44444444, up, dn);
    wait_words(1);
    repeat (3) @(negedge clk);
    chk("t5_count", 64'(words.size()), 64'd1);
    chk("t5_word", words[0], 64'h44444444_33333333);
    chk("timeouts", 64'(to_err), 64'd0);
    chk("done_timing", 64'(done_err), 64'd0);
    chk("stall_stability", 64'(stab_err), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
